ex_mem_wb_pipeline: RTL and testbench



---
 rtl/ex_mem_wb_pipeline_pkg.sv | 43 ++++
 rtl/ex_mem_wb_pipeline_forwarding_unit.sv | 39 +++
 rtl/ex_mem_wb_pipeline.sv | 133 +++++++++++++
 tb/tb_ex_mem_wb_pipeline.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_wb_pipeline_pkg.sv
// Shared types for the EX/MEM/WB back half of the pipeline.
// ALU opcodes, forward-select encoding and the pipeline register bundles.
package ex_mem_wb_pipeline_pkg;

  localparam int XLEN = 64;
  localparam int RLEN = 5;

  localparam logic [RLEN-1:0] XZR = 5'd31;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_PSB = 3'b101;
  localparam logic [2:0] ALU_LSL = 3'b110;
  localparam logic [2:0] ALU_LSR = 3'b111;

  typedef enum logic [1:0] {
    FWD_ID  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwdSel_e;

  typedef struct packed {
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] storeData;
    logic [RLEN-1:0] rd;
    logic            memRead;
    logic            memWrite;
    logic            memtoReg;
    logic            regWrite;
  } exMem_t;

  typedef struct packed {
    logic [XLEN-1:0] readData;
    logic [XLEN-1:0] aluResult;
    logic [RLEN-1:0] rd;
    logic            memtoReg;
    logic            regWrite;
  } memWb_t;

endpackage

// File: rtl/ex_mem_wb_pipeline_forwarding_unit.sv
// Operand forward selection for the EX stage.
// MEM wins over WB; XZR is never a forwarding source.
module ex_mem_wb_pipeline_forwarding_unit
  import ex_mem_wb_pipeline_pkg::*;
(
  input  logic [RLEN-1:0] srcA,
  input  logic [RLEN-1:0] srcB,
  input  logic [RLEN-1:0] rdMem,
  input  logic            regWriteMem,
  input  logic [RLEN-1:0] rdWb,
  input  logic            regWriteWb,
  output fwdSel_e         fwdA,
  output fwdSel_e         fwdB
);

  function automatic fwdSel_e pick(
    input logic [RLEN-1:0] src,
    input logic [RLEN-1:0] rdM,
    input logic            weM,
    input logic [RLEN-1:0] rdW,
    input logic            weW
  );
    fwdSel_e sel;
    sel = FWD_ID;
    if (weM && (rdM != XZR) && (rdM == src)) begin
      sel = FWD_MEM;
    end else if (weW && (rdW != XZR) && (rdW == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Select the freshest producer for each operand
  always_comb begin
    fwdA = pick(srcA, rdMem, regWriteMem, rdWb, regWriteWb);
    fwdB = pick(srcB, rdMem, regWriteMem, rdWb, regWriteWb);
  end

endmodule

// File: rtl/ex_mem_wb_pipeline.sv
// EX, MEM and WB stages: forwarding, ALU, EX/MEM and MEM/WB registers.
// Drives the data-memory port and returns the write-back triple.
module ex_mem_wb_pipeline
  import ex_mem_wb_pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            Reset,
  input  logic            ALUSrc_Ex,
  input  logic            MemRead_Ex,
  input  logic            MemWrite_Ex,
  input  logic            MemtoReg_Ex,
  input  logic            RegWrite_Ex,
  input  logic [2:0]      ALUOp_Ex,
  input  logic [RLEN-1:0] Rd_Ex,
  input  logic [RLEN-1:0] Rn_Ex,
  input  logic [RLEN-1:0] Rm_Ex,
  input  logic [XLEN-1:0] SignExt_Ex,
  input  logic [XLEN-1:0] ReadData1_Ex,
  input  logic [XLEN-1:0] ReadData2_Ex,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            Zero_Ex,
  output logic [RLEN-1:0] Rd_Mem,
  output logic [RLEN-1:0] Rd_WB,
  output logic            RegWrite_Mem,
  output logic            RegWrite_WB,
  output logic [XLEN-1:0] RegWriteData_WB
);

  exMem_t          exMem;
  memWb_t          memWb;
  fwdSel_e         fwdA;
  fwdSel_e         fwdB;
  logic [RLEN-1:0] srcB;
  logic [XLEN-1:0] wbData;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [XLEN-1:0] aluB;
  logic [XLEN-1:0] aluResult;

  // Stores read Rt through the Rd field
  assign srcB = MemWrite_Ex ? Rd_Ex : Rm_Ex;

  assign wbData = memWb.memtoReg ? memWb.readData
                                 : memWb.aluResult;

  ex_mem_wb_pipeline_forwarding_unit uFwd (
    .srcA        (Rn_Ex),
    .srcB        (srcB),
    .rdMem       (exMem.rd),
    .regWriteMem (exMem.regWrite),
    .rdWb        (memWb.rd),
    .regWriteWb  (memWb.regWrite),
    .fwdA        (fwdA),
    .fwdB        (fwdB)
  );

  // Operand A forward mux
  always_comb begin
    unique case (fwdA)
      FWD_MEM: opA = exMem.aluResult;
      FWD_WB:  opA = wbData;
      default: opA = ReadData1_Ex;
    endcase
  end

  // Operand B forward mux, also the store data
  always_comb begin
    unique case (fwdB)
      FWD_MEM: opB = exMem.aluResult;
      FWD_WB:  opB = wbData;
      default: opB = ReadData2_Ex;
    endcase
  end

  assign aluB = ALUSrc_Ex ? SignExt_Ex : opB;

  // ALU: modulo-2^64 arithmetic, logic and shifts by B[5:0]
  always_comb begin
    unique case (ALUOp_Ex)
      ALU_ADD: aluResult = opA + aluB;
      ALU_SUB: aluResult = opA - aluB;
      ALU_AND: aluResult = opA & aluB;
      ALU_ORR: aluResult = opA | aluB;
      ALU_EOR: aluResult = opA ^ aluB;
      ALU_PSB: aluResult = aluB;
      ALU_LSL: aluResult = opA << aluB[5:0];
      ALU_LSR: aluResult = opA >> aluB[5:0];
      default: aluResult = '0;
    endcase
  end

  assign Zero_Ex = (aluResult == '0);

  // EX/MEM and MEM/WB registers; reset discards in-flight work
  always_ff @(posedge clk) begin
    if (Reset) begin
      exMem <= '0;
      memWb <= '0;
    end else begin
      exMem <= '{
        aluResult: aluResult,
        storeData: opB,
        rd:        Rd_Ex,
        memRead:   MemRead_Ex,
        memWrite:  MemWrite_Ex,
        memtoReg:  MemtoReg_Ex,
        regWrite:  RegWrite_Ex
      };
      memWb <= '{
        readData:  mem_rdata,
        aluResult: exMem.aluResult,
        rd:        exMem.rd,
        memtoReg:  exMem.memtoReg,
        regWrite:  exMem.regWrite
      };
    end
  end

  assign mem_addr        = exMem.aluResult;
  assign mem_wdata       = exMem.storeData;
  assign mem_read        = exMem.memRead;
  assign mem_write       = exMem.memWrite;
  assign Rd_Mem          = exMem.rd;
  assign RegWrite_Mem    = exMem.regWrite;
  assign Rd_WB           = memWb.rd;
  assign RegWrite_WB     = memWb.regWrite;
  assign RegWriteData_WB = wbData;

endmodule

// File: tb/tb_ex_mem_wb_pipeline.sv
// Bench for ex_mem_wb_pipeline: directed cases plus a random stream
// checked against an in-order architectural register model.
module tb_ex_mem_wb_pipeline;

  logic        clk;
  logic        Reset;
  logic        ALUSrc_Ex, MemRead_Ex, MemWrite_Ex;
  logic        MemtoReg_Ex, RegWrite_Ex;
  logic [2:0]  ALUOp_Ex;
  logic [4:0]  Rd_Ex, Rn_Ex, Rm_Ex;
  logic [63:0] SignExt_Ex, ReadData1_Ex, ReadData2_Ex;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, Zero_Ex;
  logic [4:0]  Rd_Mem, Rd_WB;
  logic        RegWrite_Mem, RegWrite_WB;
  logic [63:0] RegWriteData_WB;

  ex_mem_wb_pipeline dut (
    .clk             (clk),
    .Reset           (Reset),
    .ALUSrc_Ex       (ALUSrc_Ex),
    .MemRead_Ex      (MemRead_Ex),
    .MemWrite_Ex     (MemWrite_Ex),
    .MemtoReg_Ex     (MemtoReg_Ex),
    .RegWrite_Ex     (RegWrite_Ex),
    .ALUOp_Ex        (ALUOp_Ex),
    .Rd_Ex           (Rd_Ex),
    .Rn_Ex           (Rn_Ex),
    .Rm_Ex           (Rm_Ex),
    .SignExt_Ex      (SignExt_Ex),
    .ReadData1_Ex    (ReadData1_Ex),
    .ReadData2_Ex    (ReadData2_Ex),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_rdata       (mem_rdata),
    .Zero_Ex         (Zero_Ex),
    .Rd_Mem          (Rd_Mem),
    .Rd_WB           (Rd_WB),
    .RegWrite_Mem    (RegWrite_Mem),
    .RegWrite_WB     (RegWrite_WB),
    .RegWriteData_WB (RegWriteData_WB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] memFn(input logic [63:0] a);
    return (a << 32) ^ 64'hDEAD_BEEF;
  endfunction

  // Combinational data memory: contents are a fixed function of address
  assign mem_rdata = memFn(mem_addr);

  typedef struct {
    bit          v, src, mr, mw, m2r, rw;
    logic [2:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [63:0] imm;
  } instr_t;

  typedef struct {
    bit          v, mr, mw, rw;
    logic [4:0]  rd;
    logic [63:0] addr, wdata, wb;
    bit          zero;
  } exp_t;

  typedef struct {
    bit          en;
    logic [4:0]  rd;
    logic [63:0] val;
  } wr_t;

  logic [63:0] arch [32];
  logic [63:0] rf [32];
  exp_t        expQ [$];
  wr_t         wrQ [$];
  int          nCompared = 0;
  int          nMismatch = 0;
  bit          lastLoad;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatch++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, got, want);
    end
  endtask

  function automatic logic [63:0] refAlu(input logic [2:0] op,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
    int sh;
    sh = int'(b % 64);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return b;
      3'd6:    return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic instr_t mk(input bit v, src, mr, mw, m2r, rw,
                                input logic [2:0] op,
                                input logic [4:0] rd, rn, rm,
                                input logic [63:0] imm);
    instr_t i;
    i.v = v; i.src = src; i.mr = mr; i.mw = mw;
    i.m2r = m2r; i.rw = rw; i.op = op;
    i.rd = rd; i.rn = rn; i.rm = rm; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t mkAlu(input logic [2:0] op,
                                   input logic [4:0] rd, rn, rm,
                                   input bit src,
                                   input logic [63:0] imm);
    return mk('1, src, '0, '0, '0, '1, op, rd, rn, rm, imm);
  endfunction

  function automatic instr_t mkLd(input logic [4:0] rd, rn,
                                  input logic [63:0] imm);
    return mk('1, '1, '1, '0, '1, '1, 3'd0, rd, rn, 5'd0, imm);
  endfunction

  function automatic instr_t mkSt(input logic [4:0] rt, rn,
                                  input logic [63:0] imm);
    return mk('1, '1, '0, '1, '0, '0, 3'd0, rt, rn, 5'd0, imm);
  endfunction

  function automatic instr_t mkNop();
    return mk('0, '0, '0, '0, '0, '0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
  endfunction

  task automatic resetModel();
    for (int r = 0; r < 32; r++) begin
      arch[r] = (r == 31) ? 64'd0 : 64'(r);
      rf[r]   = arch[r];
    end
    expQ.delete();
    wrQ.delete();
    lastLoad = 1'b0;
  endtask

  task automatic drive(input instr_t in, input logic [63:0] rd1,
                       input logic [63:0] rd2);
    ALUSrc_Ex    = in.src;
    MemRead_Ex   = in.mr;
    MemWrite_Ex  = in.mw;
    MemtoReg_Ex  = in.m2r;
    RegWrite_Ex  = in.rw;
    ALUOp_Ex     = in.op;
    Rd_Ex        = in.rd;
    Rn_Ex        = in.rn;
    Rm_Ex        = in.rm;
    SignExt_Ex   = in.imm;
    ReadData1_Ex = rd1;
    ReadData2_Ex = rd2;
  endtask

  task automatic checkMem(input exp_t e);
    chk("mem_read", 64'(mem_read), 64'(e.mr));
    chk("mem_write", 64'(mem_write), 64'(e.mw));
    chk("RegWrite_Mem", 64'(RegWrite_Mem), 64'(e.rw));
    if (e.v) begin
      chk("Rd_Mem", 64'(Rd_Mem), 64'(e.rd));
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_wdata", mem_wdata, e.wdata);
    end
  endtask

  task automatic checkWb(input exp_t e);
    chk("RegWrite_WB", 64'(RegWrite_WB), 64'(e.rw));
    if (e.v) begin
      chk("Rd_WB", 64'(Rd_WB), 64'(e.rd));
      chk("RegWriteData_WB", RegWriteData_WB, e.wb);
    end
  endtask

  task automatic checkZeros(input string tag);
    chk({tag, "_addr"}, mem_addr, 64'd0);
    chk({tag, "_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_rd"}, 64'(mem_read), 64'd0);
    chk({tag, "_wr"}, 64'(mem_write), 64'd0);
    chk({tag, "_RdMem"}, 64'(Rd_Mem), 64'd0);
    chk({tag, "_RwMem"}, 64'(RegWrite_Mem), 64'd0);
    chk({tag, "_RdWB"}, 64'(Rd_WB), 64'd0);
    chk({tag, "_RwWB"}, 64'(RegWrite_WB), 64'd0);
    chk({tag, "_wbData"}, RegWriteData_WB, 64'd0);
  endtask

  // One issue slot: model it in program order, present it, check stages
  task automatic step(input instr_t in);
    wr_t         w;
    exp_t        e;
    logic [4:0]  bs;
    logic [63:0] a, b, bAlu, res;
    if (wrQ.size() == 3) begin
      w = wrQ.pop_front();
      if (w.en && w.rd != 5'd31) rf[w.rd] = w.val;
    end
    bs   = in.mw ? in.rd : in.rm;
    a    = arch[in.rn];
    b    = arch[bs];
    bAlu = in.src ? in.imm : b;
    res  = refAlu(in.op, a, bAlu);
    e.v = in.v; e.mr = in.mr; e.mw = in.mw; e.rw = in.rw;
    e.rd = in.rd; e.addr = res; e.wdata = b;
    e.wb = in.m2r ? memFn(res) : res;
    e.zero = (res == 64'd0);
    w.en = in.v && in.rw; w.rd = in.rd; w.val = e.wb;
    if (w.en && in.rd != 5'd31) arch[in.rd] = e.wb;
    wrQ.push_back(w);
    expQ.push_back(e);
    drive(in, rf[in.rn], rf[bs]);
    @(negedge clk);
    if (in.v) chk("Zero_Ex", 64'(Zero_Ex), 64'(e.zero));
    if (expQ.size() >= 2) checkMem(expQ[expQ.size() - 2]);
    if (expQ.size() >= 3) begin
      checkWb(expQ[0]);
      void'(expQ.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    Reset = 1'b1;
    drive(mkNop(), 64'd0, 64'd0);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    resetModel();
    @(negedge clk);
    checkZeros(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pickReg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [63:0] pickImm();
    if ($urandom_range(0, 1) == 0) return 64'($urandom_range(0, 70));
    return {$urandom, $urandom};
  endfunction

  initial begin
    instr_t in;
    int     kind;
    Reset = 1'b1;
    drive(mkNop(), 64'd0, 64'd0);
    @(posedge clk);
    #1;
    doReset("rst");

    // X1 = X5 + X7 = 12
    step(mkAlu(3'd0, 5'd1, 5'd5, 5'd7, '0, 64'd0));
    // X1 = 3, then X2 = X1 + X1 through MEM forward
    step(mkAlu(3'd0, 5'd1, 5'd31, 5'd0, '1, 64'd3));
    step(mkAlu(3'd0, 5'd2, 5'd1, 5'd1, '0, 64'd0));
    // X3 = 9, unrelated X6, then SUB X7 = X3 - X6
    step(mkAlu(3'd0, 5'd3, 5'd4, 5'd5, '0, 64'd0));
    step(mkAlu(3'd5, 5'd6, 5'd0, 5'd0, '1, 64'd2));
    step(mkAlu(3'd1, 5'd7, 5'd3, 5'd6, '0, 64'd0));
    // Load-use with one bubble
    step(mkLd(5'd4, 5'd0, 64'd0));
    step(mkNop());
    step(mkAlu(3'd0, 5'd5, 5'd4, 5'd0, '1, 64'd1));
    // X31 is never forwarded
    step(mkAlu(3'd0, 5'd31, 5'd0, 5'd0, '1, 64'd77));
    step(mkAlu(3'd0, 5'd8, 5'd31, 5'd0, '1, 64'd0));
    step(mkSt(5'd5, 5'd2, 64'h10));

    for (int n = 0; n < 800; n++) begin
      kind = $urandom_range(0, 9);
      if (lastLoad || kind >= 8) begin
        in = mkNop();
      end else if (kind == 6) begin
        in = mkLd(pickReg(), pickReg(), pickImm());
      end else if (kind == 7) begin
        in = mkSt(pickReg(), pickReg(), pickImm());
      end else begin
        in = mkAlu(3'($urandom_range(0, 7)), pickReg(), pickReg(),
                   pickReg(), 1'($urandom_range(0, 1)), pickImm());
      end
      lastLoad = in.mr;
      step(in);
    end
    step(mkNop());
    step(mkNop());

    // Reset while a store sits in EX/MEM
    step(mkSt(5'd3, 5'd2, 64'h40));
    Reset = 1'b1;
    drive(mkNop(), 64'd0, 64'd0);
    @(negedge clk);
    chk("st_pre_rst", 64'(mem_write), 64'd1);
    doReset("rstSt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatch);
    $finish;
  end

endmodule
